// File: rtl/tlm_get_fifo_pkg.sv
// Shared types and helpers for the TLM get-port FIFO provider.
package tlm_get_fifo_pkg;

    typedef enum logic [1:0] {
        OpGet     = 2'd0,
        OpTryGet  = 2'd1,
        OpPeek    = 2'd2,
        OpTryPeek = 2'd3
    } get_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    function automatic logic is_blocking(get_op_e op);
        return (op == OpGet) || (op == OpPeek);
    endfunction

    function automatic logic is_pop(get_op_e op);
        return (op == OpGet) || (op == OpTryGet);
    endfunction

endpackage

// File: rtl/tlm_get_fifo_mem.sv
// Item storage: synchronous write, combinational read, no reset on the array.
module tlm_get_fifo_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PtrW  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PtrW-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PtrW-1:0]   raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tlm_get_fifo.sv
// TLM get-port FIFO provider: put handshake in, GET/TRY_GET/PEEK/TRY_PEEK out.
// Optional macro TLM_GET_FIFO_FLUSH_EN adds a synchronous flush input.
module tlm_get_fifo
    import tlm_get_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef TLM_GET_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              put_valid,
    output logic              put_ready,
    input  logic [DATA_W-1:0] put_data,
    input  logic              get_req,
    input  logic [1:0]        get_op,
    output logic              get_ready,
    output logic              rsp_valid,
    output logic              rsp_ok,
    output logic [DATA_W-1:0] rsp_data,
    output logic              can_get,
    output logic [CntW-1:0]   count
);

    state_e            state_q;
    get_op_e           op_q;
    get_op_e           op_in;
    logic              rsp_valid_q, rsp_ok_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [DATA_W-1:0] rd_data;
    logic              do_flush, put_fire, pop, not_empty;

`ifdef TLM_GET_FIFO_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign op_in     = get_op_e'(get_op);
    assign not_empty = (count_q != '0);
    assign put_ready = (count_q != CntW'(DEPTH));
    assign put_fire  = put_valid && put_ready && !do_flush;
    // Guard on not_empty so a flush racing an accepted request cannot underflow.
    assign pop       = (state_q == StResp) && rsp_ok_q && is_pop(op_q) && not_empty;

    assign get_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_ok_q;
    assign rsp_data  = rsp_data_q;
    assign can_get   = not_empty;
    assign count     = count_q;

    tlm_get_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (put_fire),
        .waddr (wr_ptr_q),
        .wdata (put_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (do_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (put_fire) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (put_fire && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!put_fire && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpGet;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_data_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (get_req) begin
                        op_q <= op_in;
                        if (not_empty) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_ok_q    <= 1'b1;
                            rsp_data_q  <= rd_data;
                        end else if (!is_blocking(op_in)) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (do_flush) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end else if (not_empty) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_ok_q    <= 1'b1;
                        rsp_data_q  <= rd_data;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tlm_get_fifo.sv
// Directed bench for tlm_get_fifo with a queue-based reference model.
module tb_tlm_get_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              put_valid = 1'b0;
    logic              put_ready;
    logic [31:0]       put_data = '0;
    logic              get_req = 1'b0;
    logic [1:0]        get_op = 2'd0;
    logic              get_ready;
    logic              rsp_valid;
    logic              rsp_ok;
    logic [31:0]       rsp_data;
    logic              can_get;
    logic [3:0]        count;
    logic              fl;
`ifdef TLM_GET_FIFO_FLUSH_EN
    logic              flush = 1'b0;
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    tlm_get_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TLM_GET_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .put_valid (put_valid),
        .put_ready (put_ready),
        .put_data  (put_data),
        .get_req   (get_req),
        .get_op    (get_op),
        .get_ready (get_ready),
        .rsp_valid (rsp_valid),
        .rsp_ok    (rsp_ok),
        .rsp_data  (rsp_data),
        .can_get   (can_get),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: item queue plus pending-request / response-in-flight flags.
    logic [31:0] q[$];
    bit          m_wait = 0;
    logic [1:0]  m_wop = 0;
    bit          m_resp = 0;
    bit          m_ok = 0;
    logic [31:0] m_data = 0;
    bit          m_pop = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            m_wait = 0; m_resp = 0; m_ok = 0; m_data = 0; m_pop = 0;
        end else begin
            int n;
            logic [31:0] front;
            bit nr, nok, np;
            logic [31:0] nd;
            n = q.size();
            front = (n > 0) ? q[0] : 32'h0;
            nr = 0; nok = 0; nd = 0; np = 0;
            if (!m_wait && !m_resp && get_req) begin
                if (n > 0) begin
                    nr = 1; nok = 1; nd = front; np = (get_op == 2'd0 || get_op == 2'd1);
                end else if (get_op[0]) begin
                    nr = 1;
                end else begin
                    m_wait = 1; m_wop = get_op;
                end
            end else if (m_wait) begin
                if (fl) begin
                    nr = 1; m_wait = 0;
                end else if (n > 0) begin
                    nr = 1; nok = 1; nd = front; np = (m_wop == 2'd0); m_wait = 0;
                end
            end
            if (fl) begin
                q.delete();
            end else begin
                if (m_resp && m_ok && m_pop && q.size() > 0) void'(q.pop_front());
                if (put_valid && n < DEPTH) q.push_back(put_data);
            end
            m_resp = nr; m_ok = nok; m_data = nd; m_pop = np;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("put_ready", {31'd0, put_ready}, {31'd0, q.size() < DEPTH});
            chk("get_ready", {31'd0, get_ready}, {31'd0, !m_wait && !m_resp});
            chk("count", {28'd0, count}, q.size());
            chk("can_get", {31'd0, can_get}, {31'd0, q.size() != 0});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
            if (m_resp) begin
                chk("rsp_ok", {31'd0, rsp_ok}, {31'd0, m_ok});
                chk("rsp_data", rsp_data, m_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_put(input logic [31:0] d);
        put_valid = 1'b1;
        put_data  = d;
        cyc();
        put_valid = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op);
        get_req = 1'b1;
        get_op  = op;
        cyc();
        get_req = 1'b0;
    endtask

    // Issue a request with data present (or a try_* on empty); response is due now.
    task automatic get_check(input string name, input logic [1:0] op,
                             input logic ok, input logic [31:0] d);
        do_req(op);
        chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({name, "_ok"}, {31'd0, rsp_ok}, {31'd0, ok});
        chk({name, "_data"}, rsp_data, d);
        cyc();
    endtask

    initial begin
        #12;
        chk("rst_put_ready", {31'd0, put_ready}, 32'd1);
        chk("rst_get_ready", {31'd0, get_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // In-order GETs
        do_put(32'hA1);
        do_put(32'hB2);
        do_put(32'hC3);
        get_check("get1", 2'd0, 1'b1, 32'hA1);
        get_check("get2", 2'd0, 1'b1, 32'hB2);
        get_check("get3", 2'd0, 1'b1, 32'hC3);
        chk("drained_count", {28'd0, count}, 32'd0);
        chk("drained_can_get", {31'd0, can_get}, 32'd0);

        // TRY_GET on empty
        get_check("tryget_empty", 2'd1, 1'b0, 32'h0);
        chk("tryget_count", {28'd0, count}, 32'd0);

        // PEEK / TRY_PEEK leave the item, then GET removes it
        do_put(32'h55);
        get_check("peek", 2'd2, 1'b1, 32'h55);
        get_check("trypeek", 2'd3, 1'b1, 32'h55);
        chk("peek_count", {28'd0, count}, 32'd1);
        get_check("get55", 2'd0, 1'b1, 32'h55);
        chk("get55_count", {28'd0, count}, 32'd0);

        // Blocking GET on empty released by a later put
        do_req(2'd0);
        for (int i = 0; i < 2; i++) begin
            chk("wait_get_ready", {31'd0, get_ready}, 32'd0);
            cyc();
        end
        do_put(32'h77);
        chk("wait_m1_valid", {31'd0, rsp_valid}, 32'd0);
        chk("wait_m1_count", {28'd0, count}, 32'd1);
        cyc();
        chk("wait_m2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wait_m2_ok", {31'd0, rsp_ok}, 32'd1);
        chk("wait_m2_data", rsp_data, 32'h77);
        cyc();

        // Fill, attempt overflow, then wrap the pointers
        for (int i = 0; i < DEPTH; i++) do_put(32'h100 + i);
        chk("full_count", {28'd0, count}, 32'd8);
        chk("full_put_ready", {31'd0, put_ready}, 32'd0);
        do_put(32'hDEAD);
        chk("full_drop_count", {28'd0, count}, 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            get_check("wrap_get", 2'd0, 1'b1, 32'h100 + i);
            do_put(32'h200 + i);
        end
        for (int i = 0; i < DEPTH; i++) get_check("wrap_drain", 2'd0, 1'b1, 32'h200 + i);
        chk("wrap_count", {28'd0, count}, 32'd0);

        // Async reset during WAIT
        do_req(2'd2);
        cyc();
        #3 rst = 1'b1;
        #1;
        chk("arst_get_ready", {31'd0, get_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_count", {28'd0, count}, 32'd0);
        chk("arst_put_ready", {31'd0, put_ready}, 32'd1);
        #12 rst = 1'b0;
        cyc();
        do_put(32'h99);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            cyc();
        end
        get_check("post_rst_get", 2'd0, 1'b1, 32'h99);

`ifdef TLM_GET_FIFO_FLUSH_EN
        do_req(2'd0);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_abort_valid", {31'd0, rsp_valid}, 32'd1);
        chk("flush_abort_ok", {31'd0, rsp_ok}, 32'd0);
        chk("flush_abort_data", rsp_data, 32'h0);
        cyc();
        do_put(32'h1);
        do_put(32'h2);
        flush = 1'b1;
        put_valid = 1'b1;
        put_data = 32'h3;
        cyc();
        flush = 1'b0;
        put_valid = 1'b0;
        chk("flush_count", {28'd0, count}, 32'd0);
`endif

        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
